gat_load_sched: RTL and testbench

//  Load/run sequencer in front of gat_top. Accepts one tagged 32-bit word stream from the host DMA and steers

---
 rtl/gat_load_pkg.sv | 16 +
 rtl/gat_load_tgt_cnt.sv | 47 ++++
 rtl/gat_load_sched.sv | 140 ++++++++++++++
 tb/tb_gat_load_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_load_pkg.sv
// Shared types and helpers for the GAT load/run sequencer.
// Target encoding matches the s_sel stream tag.
package gat_load_pkg;

  localparam int NUM_TGT = 4;

  typedef enum logic [1:0] {TGT_HDATA, TGT_NINFO, TGT_WGT, TGT_SUBG} tgt_e;

  typedef enum {S_IDLE, S_LOAD, S_WAIT_LO, S_WAIT_HI} load_st_e;

  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [1:0] t);
    tgt_onehot    = '0;
    tgt_onehot[t] = 1'b1;
  endfunction

endpackage

// File: rtl/gat_load_tgt_cnt.sv
// Per-target word counter: holds the programmed length, counts accepted writes,
// flags the final write (done) and words arriving for an already-full target (ovf).
module gat_load_tgt_cnt #(
  parameter int ADDR_W = 19,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  len_in,
  input  logic              hs,
  output logic              wr,
  output logic              ovf,
  output logic [ADDR_W-1:0] idx,
  output logic              done
);

  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic             full;

  assign full = (cnt == len_q);
  assign wr   = hs && !full;
  assign ovf  = hs && full;
  assign idx  = cnt[ADDR_W-1:0];

  // done is registered alongside the write strobe so it rises with the final write
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else if (abort) begin
      cnt   <= '0;
      done  <= 1'b0;
    end else if (start) begin
      len_q <= len_in;
      cnt   <= '0;
      done  <= (len_in == '0);
    end else if (wr) begin
      cnt <= cnt + CNT_W'(1);
      if (cnt == len_q - CNT_W'(1)) done <= 1'b1;
    end
  end

endmodule

// File: rtl/gat_load_sched.sv
// Load/run sequencer in front of gat_top: steers a tagged word stream into four BRAM ports,
// then waits for a fresh gat_ready rising edge. Optional GAT_LOAD_PERF_CNT_EN adds cycle counters.
module gat_load_sched
  import gat_load_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int ADDR_W    = 19,
  parameter int CNT_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_W-1:0]     cfg_len_0,
  input  logic [CNT_W-1:0]     cfg_len_1,
  input  logic [CNT_W-1:0]     cfg_len_2,
  input  logic [CNT_W-1:0]     cfg_len_3,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [1:0]           s_sel,
  input  logic [TOP_WIDTH-1:0] s_data,
  output logic [TOP_WIDTH-1:0] bram_din,
  output logic [3:0]           bram_ena,
  output logic [3:0]           bram_wea,
  output logic [ADDR_W+1:0]    bram_addra,
  output logic [3:0]           load_done,
  input  logic                 gat_ready,
  output logic                 run_busy,
  output logic                 run_done,
  output logic                 err_ovf
`ifdef GAT_LOAD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_load_cyc,
  output logic [31:0]          perf_run_cyc
`endif
);

  load_st_e state, state_nxt;

  logic                 start_acc;
  logic                 hs;
  logic [CNT_W-1:0]     len_in  [NUM_TGT];
  logic [NUM_TGT-1:0]   tgt_hs;
  logic [NUM_TGT-1:0]   tgt_wr;
  logic [NUM_TGT-1:0]   tgt_ovf;
  logic [NUM_TGT-1:0]   tgt_done;
  logic [ADDR_W-1:0]    tgt_idx [NUM_TGT];

  assign len_in[0] = cfg_len_0;
  assign len_in[1] = cfg_len_1;
  assign len_in[2] = cfg_len_2;
  assign len_in[3] = cfg_len_3;

  // abort outranks start and blocks any write in the same cycle
  assign start_acc = cfg_start && !cfg_abort && (state == S_IDLE);
  assign hs        = s_valid && s_ready && !cfg_abort;
  assign tgt_hs    = hs ? tgt_onehot(s_sel) : '0;

  for (genvar t = 0; t < NUM_TGT; t++) begin : g_tgt
    gat_load_tgt_cnt #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .start  (start_acc),
      .abort  (cfg_abort),
      .len_in (len_in[t]),
      .hs     (tgt_hs[t]),
      .wr     (tgt_wr[t]),
      .ovf    (tgt_ovf[t]),
      .idx    (tgt_idx[t]),
      .done   (tgt_done[t])
    );
  end

  assign load_done = tgt_done;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // WAIT_LO demands gat_ready low first so a stale high level is never read as completion
  always_comb begin
    state_nxt = state;
    if (cfg_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (cfg_start)  state_nxt = S_LOAD;
        S_LOAD:    if (&tgt_done)  state_nxt = S_WAIT_LO;
        S_WAIT_LO: if (!gat_ready) state_nxt = S_WAIT_HI;
        S_WAIT_HI: if (gat_ready)  state_nxt = S_IDLE;
        default:                   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready  = (state == S_LOAD);
    run_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bram_ena   <= '0;
      bram_din   <= '0;
      bram_addra <= '0;
      err_ovf    <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      bram_ena <= tgt_wr;
      run_done <= !cfg_abort && (state == S_WAIT_HI) && gat_ready;
      if (|tgt_wr) begin
        bram_din   <= s_data;
        bram_addra <= {tgt_idx[s_sel], 2'b00};
      end
      if (cfg_abort || start_acc) err_ovf <= 1'b0;
      else if (|tgt_ovf)          err_ovf <= 1'b1;
    end
  end

  assign bram_wea = bram_ena;

`ifdef GAT_LOAD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      perf_load_cyc <= '0;
      perf_run_cyc  <= '0;
    end else begin
      if ((state == S_LOAD) && (perf_load_cyc != '1))
        perf_load_cyc <= perf_load_cyc + 32'd1;
      if (((state == S_WAIT_LO) || (state == S_WAIT_HI)) && (perf_run_cyc != '1))
        perf_run_cyc <= perf_run_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gat_load_sched.sv
// Directed self-checking bench for gat_load_sched: table-driven load stream plus
// hand-written sequences for completion, zero length, overflow, abort and reset.
module tb_gat_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort;
  logic [19:0] cfg_len_0, cfg_len_1, cfg_len_2, cfg_len_3;
  logic        s_valid, s_ready;
  logic [1:0]  s_sel;
  logic [31:0] s_data;
  logic [31:0] bram_din;
  logic [3:0]  bram_ena, bram_wea, load_done;
  logic [20:0] bram_addra;
  logic        gat_ready, run_busy, run_done, err_ovf;
`ifdef GAT_LOAD_PERF_CNT_EN
  logic [31:0] perf_load_cyc, perf_run_cyc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gat_load_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .cfg_len_0  (cfg_len_0),
    .cfg_len_1  (cfg_len_1),
    .cfg_len_2  (cfg_len_2),
    .cfg_len_3  (cfg_len_3),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sel      (s_sel),
    .s_data     (s_data),
    .bram_din   (bram_din),
    .bram_ena   (bram_ena),
    .bram_wea   (bram_wea),
    .bram_addra (bram_addra),
    .load_done  (load_done),
    .gat_ready  (gat_ready),
    .run_busy   (run_busy),
    .run_done   (run_done),
    .err_ovf    (err_ovf)
`ifdef GAT_LOAD_PERF_CNT_EN
    ,
    .perf_load_cyc (perf_load_cyc),
    .perf_run_cyc  (perf_run_cyc)
`endif
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ena;
    logic [20:0] addr;
    logic [3:0]  done;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one clock; outputs are then stable for checking and inputs may change
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lens(input int l0, input int l1, input int l2, input int l3);
    cfg_len_0 = 20'(l0);
    cfg_len_1 = 20'(l1);
    cfg_len_2 = 20'(l2);
    cfg_len_3 = 20'(l3);
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] data);
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_start = 0; cfg_abort = 0; s_valid = 0; s_sel = 0; s_data = 0;
    gat_ready = 0;
    set_lens(0, 0, 0, 0);

    // 10-word interleaved stream for lens {3,2,4,1}
    tbl[0] = '{2'd0, 32'hA000_0000, 4'b0001, 21'd0,  4'b0000};
    tbl[1] = '{2'd1, 32'hA000_0001, 4'b0010, 21'd0,  4'b0000};
    tbl[2] = '{2'd2, 32'hA000_0002, 4'b0100, 21'd0,  4'b0000};
    tbl[3] = '{2'd3, 32'hA000_0003, 4'b1000, 21'd0,  4'b1000};
    tbl[4] = '{2'd0, 32'hA000_0004, 4'b0001, 21'd4,  4'b1000};
    tbl[5] = '{2'd1, 32'hA000_0005, 4'b0010, 21'd4,  4'b1010};
    tbl[6] = '{2'd2, 32'hA000_0006, 4'b0100, 21'd4,  4'b1010};
    tbl[7] = '{2'd0, 32'hA000_0007, 4'b0001, 21'd8,  4'b1011};
    tbl[8] = '{2'd2, 32'hA000_0008, 4'b0100, 21'd8,  4'b1011};
    tbl[9] = '{2'd2, 32'hA000_0009, 4'b0100, 21'd12, 4'b1111};

    tick(); tick();
    rst = 1'b0;
    chk("rst_s_ready",   s_ready,    0);
    chk("rst_ena",       bram_ena,   0);
    chk("rst_load_done", load_done,  0);
    chk("rst_run_busy",  run_busy,   0);
    chk("rst_run_done",  run_done,   0);
    chk("rst_addr",      bram_addra, 0);

    // 1: interleaved load, gat_ready held high throughout (stale level)
    gat_ready = 1'b1;
    set_lens(3, 2, 4, 1);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t1_s_ready", s_ready, 1);
    chk("t1_busy",    run_busy, 1);
    chk("t1_done0",   load_done, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_sel = tbl[i].sel; s_data = tbl[i].data;
      tick();
      chk($sformatf("t1_ena_%0d", i),  bram_ena,   tbl[i].ena);
      chk($sformatf("t1_wea_%0d", i),  bram_wea,   tbl[i].ena);
      chk($sformatf("t1_addr_%0d", i), bram_addra, tbl[i].addr);
      chk($sformatf("t1_din_%0d", i),  bram_din,   tbl[i].data);
      chk($sformatf("t1_done_%0d", i), load_done,  tbl[i].done);
    end
    s_valid = 1'b0;
    chk("t1_still_load", s_ready, 1);
    tick();
    chk("t1_wait_lo_ready", s_ready, 0);
    chk("t1_wait_lo_busy",  run_busy, 1);
    chk("t1_wait_lo_ena",   bram_ena, 0);
    chk("t1_no_ovf",        err_ovf, 0);

    // 2: stale high ignored, then low 5 cycles, then rise
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_stale_done", run_done, 0);
      chk("t2_stale_busy", run_busy, 1);
    end
    gat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_low_done", run_done, 0);
      chk("t2_low_busy", run_busy, 1);
    end
    gat_ready = 1'b1;
    tick();
    chk("t2_run_done", run_done, 1);
    chk("t2_idle_busy", run_busy, 0);
    chk("t2_done_hold", load_done, 4'b1111);
    tick();
    chk("t2_done_pulse", run_done, 0);

    // 3: zero length target completes immediately
    set_lens(3, 1, 0, 1);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t3_len0_done", load_done, 4'b0100);
    chk("t3_no_ena", bram_ena, 0);
    send(2'd0, 32'h5555_0000);
    chk("t3_wr_ena",  bram_ena, 4'b0001);
    chk("t3_wr_addr", bram_addra, 0);

    // 5: abort with start in the same cycle
    set_lens(1, 1, 1, 1);
    cfg_abort = 1'b1; cfg_start = 1'b1; s_valid = 1'b1; s_sel = 2'd1;
    tick();
    cfg_abort = 1'b0; cfg_start = 1'b0; s_valid = 1'b0;
    chk("t5_busy",  run_busy, 0);
    chk("t5_done",  load_done, 0);
    chk("t5_ena",   bram_ena, 0);
    chk("t5_ready", s_ready, 0);
    chk("t5_no_run_done", run_done, 0);
    tick();
    chk("t5_stays_idle", run_busy, 0);

    // 4: overflow on a 2-word target, restart begins at address 0
    set_lens(2, 0, 0, 0);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t4_done_init", load_done, 4'b1110);
    chk("t4_busy", run_busy, 1);
    s_valid = 1'b1; s_sel = 2'd0;
    s_data = 32'hD000_0001; tick();
    chk("t4_w1_ena",  bram_ena, 4'b0001);
    chk("t4_w1_addr", bram_addra, 0);
    chk("t4_w1_done", load_done, 4'b1110);
    s_data = 32'hD000_0002; tick();
    chk("t4_w2_ena",  bram_ena, 4'b0001);
    chk("t4_w2_addr", bram_addra, 4);
    chk("t4_w2_done", load_done, 4'b1111);
    chk("t4_w2_ovf",  err_ovf, 0);
    s_data = 32'hD000_0003; tick();
    s_valid = 1'b0;
    chk("t4_w3_ena",  bram_ena, 0);
    chk("t4_w3_ovf",  err_ovf, 1);
    chk("t4_w3_addr", bram_addra, 4);
    chk("t4_w3_din",  bram_din, 32'hD000_0002);
    chk("t4_wait_lo", s_ready, 0);
    tick();
    chk("t4_ovf_sticky", err_ovf, 1);
    gat_ready = 1'b0; tick();
    gat_ready = 1'b1; tick();
    chk("t4_run_done", run_done, 1);
    chk("t4_ovf_idle", err_ovf, 1);
    set_lens(1, 1, 1, 1);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t4_ovf_clr", err_ovf, 0);
    chk("t4_done_clr", load_done, 0);

    // 6: reset while in WAIT_HI
    for (int i = 0; i < 4; i++) send(2'(i), 32'hC000_0000 + 32'(i));
    chk("t6_all_done", load_done, 4'b1111);
    tick();
    gat_ready = 1'b0; tick();
    chk("t6_wait_hi_busy", run_busy, 1);
    chk("t6_wait_hi_done", run_done, 0);
`ifdef GAT_LOAD_PERF_CNT_EN
    chk("t6_perf_load", perf_load_cyc, 5);
    chk("t6_perf_run",  perf_run_cyc, 1);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_ready", s_ready, 0);
    chk("t6_rst_ena",   bram_ena, 0);
    chk("t6_rst_wea",   bram_wea, 0);
    chk("t6_rst_din",   bram_din, 0);
    chk("t6_rst_addr",  bram_addra, 0);
    chk("t6_rst_done",  load_done, 0);
    chk("t6_rst_busy",  run_busy, 0);
    chk("t6_rst_rdone", run_done, 0);
    chk("t6_rst_ovf",   err_ovf, 0);
`ifdef GAT_LOAD_PERF_CNT_EN
    chk("t6_rst_perf_load", perf_load_cyc, 0);
    chk("t6_rst_perf_run",  perf_run_cyc, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
